// File: rtl/axis_fifo_stream_master_pkg.sv
// Shared FSM encoding and default data width for the FIFO-to-AXI-Stream master.
package axis_fifo_stream_master_pkg;

    localparam int DEFAULT_TDATA_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_POP  = 2'd1;
    localparam state_t ST_LOAD = 2'd2;
    localparam state_t ST_SEND = 2'd3;

endpackage

// File: rtl/axis_fifo_stream_master.sv
// Drains a one-cycle-latency FIFO onto an AXI-Stream master port, one word per
// IDLE/POP/LOAD/SEND pass, flagging TLAST on the word that empties the FIFO after a finish.
module axis_fifo_stream_master
    import axis_fifo_stream_master_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = DEFAULT_TDATA_WIDTH
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESETN,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
    input  logic                                M_AXIS_TREADY,
    output logic                                M_AXIS_TLAST,
    input  logic                                empty,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     fifo_data,
    output logic                                pop_en,
    input  logic                                receive_finish
);

    state_t                            state;
    state_t                            state_nxt;
    logic                              tvalid_q;
    logic                              tlast_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   tdata_q;
    logic                              finish_pending;
    logic                              handshake;

    assign handshake     = tvalid_q & M_AXIS_TREADY;
    assign pop_en        = (state == ST_POP);
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TKEEP  = '1;

    always_comb begin
        // NOTE: defaulting state_nxt first gives every path an assignment, so no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: if (!empty) state_nxt = ST_POP;
            ST_POP:  state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: if (handshake) state_nxt = empty ? ST_IDLE : ST_POP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop here samples the pre-edge values.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state          <= ST_IDLE;
            tvalid_q       <= 1'b0;
            tlast_q        <= 1'b0;
            tdata_q        <= '0;
            finish_pending <= 1'b0;
        end else begin
            state <= state_nxt;

            // fifo_data is valid in LOAD; empty already reflects the pop issued in POP.
            if (state == ST_LOAD) begin
                tdata_q  <= fifo_data;
                tvalid_q <= 1'b1;
                tlast_q  <= (finish_pending | receive_finish) & empty;
            end else if (handshake) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            // A finish that arrives after the final word already left must not linger.
            if (receive_finish) begin
                finish_pending <= 1'b1;
            end else if ((handshake & tlast_q) | ((state == ST_IDLE) & empty)) begin
                finish_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo_stream_master.sv
// Directed bench: upstream FIFO model, scoreboard monitor, vector table and corner sequences.
module tb_axis_fifo_stream_master;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           tvalid;
    logic           tready = 1'b0;
    logic           tlast;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           empty;
    logic [W-1:0]   fifo_data;
    logic           pop_en;
    logic           receive_finish = 1'b0;
    logic           wr_en = 1'b0;
    logic [W-1:0]   wr_data = '0;

    always #5 clk = ~clk;

    axis_fifo_stream_master #(.C_M_AXIS_TDATA_WIDTH(W)) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TKEEP   (tkeep),
        .M_AXIS_TREADY  (tready),
        .M_AXIS_TLAST   (tlast),
        .empty          (empty),
        .fifo_data      (fifo_data),
        .pop_en         (pop_en),
        .receive_finish (receive_finish)
    );

    // Upstream synchronous FIFO: registered empty flag, read data one cycle after pop.
    logic [W-1:0] fmem [0:63];
    logic [6:0]   wptr;
    logic [6:0]   rptr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            empty     <= 1'b1;
            fifo_data <= '0;
        end else begin
            if (wr_en) fmem[wptr[5:0]] <= wr_data;
            if (pop_en) fifo_data <= fmem[rptr[5:0]];
            wptr  <= wptr + 7'(wr_en);
            rptr  <= rptr + 7'(pop_en);
            empty <= ((wptr + 7'(wr_en)) == (rptr + 7'(pop_en)));
        end
    end

    int n_checks = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [W-1:0] exp_data [$];
    logic         exp_last [$];
    int           beats = 0;
    int           lasts = 0;
    int           pops = 0;
    int           cyc = 0;
    int           last_beat_cyc = 0;
    int           beat_gap = 0;
    logic         mon_en = 1'b0;

    // Monitor on the falling edge: sees the values the next rising edge will act on.
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_data;
        logic         prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && mon_en) begin
                if (prev_stall) begin
                    check("hold_valid", 64'(tvalid), 64'(1));
                    check("hold_data", 64'(tdata), 64'(prev_data));
                    check("hold_last", 64'(tlast), 64'(prev_last));
                end
                if (tvalid && !tready) check("pop_while_stalled", 64'(pop_en), 64'(0));
                if (pop_en) begin
                    pops++;
                    check("pop_nonempty", 64'(empty), 64'(0));
                end
                if (tvalid && tready) begin
                    beat_gap      = cyc - last_beat_cyc;
                    last_beat_cyc = cyc;
                    beats++;
                    if (tlast) lasts++;
                    if (exp_data.size() == 0) begin
                        check("extra_beat", 64'(exp_data.size()), 64'(1));
                    end else begin
                        check("beat_data", 64'(tdata), 64'(exp_data.pop_front()));
                        check("beat_last", 64'(tlast), 64'(exp_last.pop_front()));
                    end
                end
                prev_stall = tvalid && !tready;
                prev_data  = tdata;
                prev_last  = tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_packet(input int first, input int count, input int gap, input logic last_flag);
        for (int i = 0; i < count; i++) begin
            wr_en   = 1'b1;
            wr_data = W'(first + i);
            exp_data.push_back(W'(first + i));
            exp_last.push_back(last_flag && (i == count - 1));
            tick();
        end
        wr_en = 1'b0;
        if (gap > 1) tick(gap - 1);
        receive_finish = 1'b1;
        tick();
        receive_finish = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget);
        int t;
        t = 0;
        while (beats < target && t < budget) begin
            tick();
            t++;
        end
        if (beats < target) check("timeout_beats", 64'(beats), 64'(target));
    endtask

    task automatic end_packet(input int e_beats, input int e_lasts, input int e_pops);
        tick(8);
        check("beat_count", 64'(beats), 64'(e_beats));
        check("last_count", 64'(lasts), 64'(e_lasts));
        check("pop_count", 64'(pops), 64'(e_pops));
        check("sb_drained", 64'(exp_data.size()), 64'(0));
        check("idle_valid", 64'(tvalid), 64'(0));
    endtask

    task automatic clear_counts();
        beats = 0;
        lasts = 0;
        pops  = 0;
    endtask

    typedef struct {
        int   first;
        int   count;
        int   gap;
        int   ready_delay;
        logic last_on_final;
        int   exp_beats;
        int   exp_lasts;
        int   exp_pops;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   lat;
        logic any_valid;
        logic any_pop;

        vecs[0] = '{first: 5,          count: 16, gap: 1,  ready_delay: 10, last_on_final: 1'b1, exp_beats: 16, exp_lasts: 1, exp_pops: 16};
        vecs[1] = '{first: 42,         count: 1,  gap: 1,  ready_delay: -1, last_on_final: 1'b1, exp_beats: 1,  exp_lasts: 1, exp_pops: 1};
        vecs[2] = '{first: 77,         count: 1,  gap: 10, ready_delay: -1, last_on_final: 1'b0, exp_beats: 1,  exp_lasts: 0, exp_pops: 1};
        vecs[3] = '{first: 88,         count: 1,  gap: 10, ready_delay: -1, last_on_final: 1'b0, exp_beats: 1,  exp_lasts: 0, exp_pops: 1};
        vecs[4] = '{first: 100,        count: 4,  gap: 1,  ready_delay: -1, last_on_final: 1'b1, exp_beats: 4,  exp_lasts: 1, exp_pops: 4};
        vecs[5] = '{first: 'h5A5A0000, count: 3,  gap: 1,  ready_delay: 0,  last_on_final: 1'b1, exp_beats: 3,  exp_lasts: 1, exp_pops: 3};

        // Asynchronous reset, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_tvalid", 64'(tvalid), 64'(0));
        check("rst_tlast", 64'(tlast), 64'(0));
        check("rst_pop_en", 64'(pop_en), 64'(0));
        check("rst_tdata", 64'(tdata), 64'(0));
        check("rst_tkeep", 64'(tkeep), 64'('hF));
        tick(2);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(2);

        for (int v = 0; v < 6; v++) begin
            clear_counts();
            tready = (vecs[v].ready_delay < 0);
            write_packet(vecs[v].first, vecs[v].count, vecs[v].gap, vecs[v].last_on_final);
            if (vecs[v].ready_delay >= 0) begin
                tick(vecs[v].ready_delay);
                tready = 1'b1;
            end
            wait_beats(vecs[v].exp_beats, 400);
            end_packet(vecs[v].exp_beats, vecs[v].exp_lasts, vecs[v].exp_pops);
        end

        // Back-pressure mid-burst, with the steady-state beat interval checked first.
        clear_counts();
        tready = 1'b1;
        write_packet(5, 16, 1, 1'b1);
        wait_beats(6, 100);
        check("beat_interval", 64'(beat_gap), 64'(3));
        tready = 1'b0;
        tick(20);
        tready = 1'b1;
        wait_beats(16, 400);
        end_packet(16, 1, 16);

        // Finish arrives while stalled, then a ragged ready pattern.
        clear_counts();
        tready = 1'b0;
        write_packet(5, 16, 1, 1'b1);
        tready = 1'b1; tick(14);
        tready = 1'b0; tick(24);
        tready = 1'b1; tick(2);
        tready = 1'b0; tick(20);
        tready = 1'b1;
        wait_beats(16, 400);
        end_packet(16, 1, 16);

        // A TLAST beat held across a long stall.
        clear_counts();
        tready = 1'b0;
        write_packet(300, 1, 1, 1'b1);
        tick(40);
        check("held_last_valid", 64'(tvalid), 64'(1));
        check("held_last_flag", 64'(tlast), 64'(1));
        check("held_last_data", 64'(tdata), 64'(300));
        tready = 1'b1;
        wait_beats(1, 20);
        end_packet(1, 1, 1);

        // Empty-to-valid latency.
        clear_counts();
        tready = 1'b1;
        wr_en = 1'b1;
        wr_data = 32'h0BAD_CAFE;
        exp_data.push_back(32'h0BAD_CAFE);
        exp_last.push_back(1'b1);
        tick();
        wr_en = 1'b0;
        receive_finish = 1'b1;
        lat = 0;
        while (!tvalid && lat < 20) begin
            tick();
            receive_finish = 1'b0;
            lat++;
        end
        check("latency", 64'(lat), 64'(3));
        end_packet(1, 1, 1);

        // receive_finish lands exactly in the LOAD cycle of the final word.
        clear_counts();
        wr_en = 1'b1;
        wr_data = 32'h1234_5678;
        exp_data.push_back(32'h1234_5678);
        exp_last.push_back(1'b1);
        tick();
        wr_en = 1'b0;
        lat = 0;
        while (!pop_en && lat < 10) begin
            tick();
            lat++;
        end
        check("pop_seen", 64'(pop_en), 64'(1));
        tick();
        receive_finish = 1'b1;
        tick();
        receive_finish = 1'b0;
        wait_beats(1, 20);
        end_packet(1, 1, 1);

        // Empty FIFO with ready high: nothing moves.
        clear_counts();
        any_valid = 1'b0;
        any_pop   = 1'b0;
        repeat (50) begin
            tick();
            if (tvalid) any_valid = 1'b1;
            if (pop_en) any_pop = 1'b1;
        end
        check("idle_no_valid", 64'(any_valid), 64'(0));
        check("idle_no_pop", 64'(any_pop), 64'(0));

        // Reset in the middle of a stalled beat discards it; the next packet starts clean.
        clear_counts();
        tready = 1'b0;
        write_packet('hDEAD0001, 2, 1, 1'b1);
        tick(5);
        check("pre_rst_valid", 64'(tvalid), 64'(1));
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(tvalid), 64'(0));
        check("mid_rst_tlast", 64'(tlast), 64'(0));
        check("mid_rst_pop_en", 64'(pop_en), 64'(0));
        check("mid_rst_tdata", 64'(tdata), 64'(0));
        exp_data.delete();
        exp_last.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        clear_counts();
        tready = 1'b1;
        write_packet(500, 2, 1, 1'b1);
        wait_beats(2, 50);
        end_packet(2, 1, 2);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_fifo_stream_master.md
Name: axis_fifo_stream_master

Overview:
AXI4-Stream master that drains words from an upstream synchronous FIFO and presents them on an AXI-Stream master port. A one-cycle `receive_finish` pulse from the producer marks the end of a packet. The master asserts TLAST on the beat that carries the final word in the FIFO after that pulse. It sits between the producer-side FIFO (one-cycle read latency) and a downstream AXI-Stream slave.

Parameters:
- C_M_AXIS_TDATA_WIDTH, default 32: width of TDATA and of fifo_data. Must be a multiple of 8.

Ports:
- M_AXIS_ACLK  in  1  clock; all logic on rising edge.
- M_AXIS_ARESETN  in  1  asynchronous active-low reset.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  stream data.
- M_AXIS_TKEEP  out  C_M_AXIS_TDATA_WIDTH/8  byte qualifiers, constant all ones.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  last beat of packet.
- empty  in  1  FIFO empty flag, registered in the FIFO.
- fifo_data  in  C_M_AXIS_TDATA_WIDTH  FIFO read data; valid the cycle after a pop.
- pop_en  out  1  FIFO read strobe; one word per high cycle.
- receive_finish  in  1  single-cycle pulse: producer has written the last word of the packet.

Behaviour:
- Interface (decided): one clock, M_AXIS_ACLK; reset M_AXIS_ARESETN is asynchronous and active-low.
- Reset values: TVALID=0, TLAST=0, TDATA=0, pop_en=0, state=IDLE, finish_pending=0. TKEEP is always all ones.
- Reset mid-operation discards any word in flight. The next packet restarts from IDLE.
- finish_pending register:
  - Set on receive_finish.
  - Cleared on the handshake (TVALID&TREADY) of a TLAST beat.
  - If receive_finish coincides with that handshake, set wins.
- FSM states: IDLE, POP, LOAD, SEND.
- IDLE: if !empty, go to POP; otherwise stay. TVALID=0.
- POP: pop_en=1 for exactly this cycle, then go to LOAD. pop_en is never asserted while empty=1.
- LOAD:
  - Capture fifo_data into TDATA.
  - Set TVALID=1.
  - Set TLAST = (finish_pending | receive_finish) & empty, where `empty` is the post-pop value.
  - Go to SEND.
- SEND:
  - Hold TDATA, TLAST and TVALID stable until TREADY=1. Payload never changes while TVALID=1 and TREADY=0.
  - On handshake, TVALID drops.
  - Next state: POP if !empty, else IDLE.
- Throughput: one beat per 3 cycles when TREADY is held high. Latency from empty falling to TVALID high is 3 cycles.
- If a word was sent with TLAST=0 and receive_finish then arrives while the FIFO stays empty, no extra beat is generated. finish_pending is cleared in IDLE when empty=1. Producers must pulse receive_finish no earlier than the cycle after their final write.
- A TLAST beat with TREADY low is held indefinitely, e.g. across long back-pressure.
- Writes into the FIFO while the master is in SEND are picked up after the handshake.

Decomposition:
- Shared package: FSM state encoding (IDLE/POP/LOAD/SEND, 2-bit typedef) and default TDATA width constant.
- No sub-module needed. Single module: FSM, data/last registers, finish_pending flag.

Test Plan:
- Reset: ARESETN low for 1 cycle → TVALID=0, TLAST=0, pop_en=0, TDATA=0 immediately, asynchronously.
- Burst with late ready:
  - Stimulus: write 5..20 (16 words), pulse receive_finish the cycle after the last write, hold TREADY low, then raise it.
  - Required: 16 beats 5..20 in order; TLAST=1 only with data 20; exactly 16 pops.
- Back-pressure: drop TREADY for 20 cycles mid-burst → TDATA/TLAST stable while TVALID=1; no pop_en while stalled; no lost or duplicated words.
- Second packet, finish while stalled:
  - Stimulus: TREADY=0, write 5..20, pulse receive_finish, then toggle TREADY (14 cycles on, 24 off, 2 on, 20 off, on).
  - Required: all 16 beats delivered; TLAST on 20 only; TLAST beat held until accepted.
- Simultaneous: receive_finish in the LOAD cycle of the final word → that beat carries TLAST=1.
- Empty FIFO idle: no writes, TREADY=1 for 50 cycles → TVALID and pop_en stay 0.
